// File: rtl/mem_responder_6502.sv
// Memory-side responder for the 6502 cache/memory request interface, backed by a synchronous byte RAM.
// Define MEM_RESPONDER_WBURST_EN to accept mem_wburst write bursts; otherwise every write is single-beat.
module mem_responder_6502 #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned BEAT_WAIT = 0,
  parameter int unsigned BURST_LEN = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] mem_addr,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic        mem_rburst,
  input  logic        mem_wburst,
  input  logic [7:0]  mem_wdata,
  output logic        mem_rdy,
  output logic [7:0]  mem_rdata,
  output logic [7:0]  mem_rdata0,
  output logic        mem_rdata_load
);

  localparam int unsigned        CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0]  LINE_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(BURST_LEN - 1);
  localparam logic [3:0]         LAT_M1    = 4'(LATENCY - 1);
  localparam logic [3:0]         GAP_M1    = (BEAT_WAIT == 0) ? 4'd0 : 4'(BEAT_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                burst_q, burst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          wait_q, wait_d;
  logic [7:0]          rdata_q, rdata_d;

  logic [7:0]          ram [0:(1 << ADDR_W) - 1];
  logic [7:0]          ram_rd_q;
  logic                rd_en;
  logic                beat;
  logic                last_beat;
  logic                burst_req;
  logic [ADDR_W-1:0]   beat_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [23:0]         unused_addr;

  // Bits above ADDR_W alias; they are deliberately not decoded.
  assign unused_addr = mem_addr;

`ifdef MEM_RESPONDER_WBURST_EN
  assign burst_req = mem_wr ? mem_wburst : mem_rburst;
`else
  logic unused_wburst;
  assign unused_wburst = mem_wburst;
  assign burst_req     = mem_rburst && !mem_wr;
`endif

  // Byte k of a transaction: wraps inside the aligned line, never carries into the line address.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [CNT_W-1:0]  k);
    line_addr = (a & ~LINE_MASK) | ((a + ADDR_W'(k)) & LINE_MASK);
  endfunction

  assign beat      = (state_q == S_BEAT);
  assign last_beat = !burst_q || (cnt_q == LAST_CNT);
  assign beat_addr = line_addr(addr_q, cnt_q);
  assign rd_addr   = line_addr(addr_q, cnt_d);

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          addr_d  = mem_addr[ADDR_W-1:0];
          wr_d    = mem_wr;
          burst_d = burst_req;
          cnt_d   = '0;
          wait_d  = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          rd_en   = 1'b1;
          state_d = S_BEAT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_BEAT: begin
        if (last_beat) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (BEAT_WAIT == 0) begin
            rd_en = 1'b1;
          end else begin
            wait_d  = GAP_M1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (wait_q == 4'd0) begin
          rd_en   = 1'b1;
          state_d = S_BEAT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
    endcase
  end

  assign rdata_d = beat ? mem_rdata0 : rdata_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      burst_q <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the RAM array and its read register are never reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (beat && wr_q) ram[beat_addr] <= mem_wdata;
    if (rd_en)        ram_rd_q       <= ram[rd_addr];
  end

  assign mem_rdy        = (state_q == S_IDLE);
  assign mem_rdata_load = beat;
  assign mem_rdata0     = !beat ? 8'h00 : (wr_q ? mem_wdata : ram_rd_q);
  assign mem_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_responder_6502.sv
// Self-checking bench for mem_responder_6502: randomized requests checked against a byte-array model.
// Expectations follow MEM_RESPONDER_WBURST_EN when it is defined for the build.
module tb_mem_responder_6502;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LAT    = 1;
  localparam int unsigned BW     = 0;
  localparam int unsigned BL     = 8;
`ifdef MEM_RESPONDER_WBURST_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] mem_addr = '0;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic        mem_rburst = 1'b0;
  logic        mem_wburst = 1'b0;
  logic [7:0]  mem_wdata = '0;
  logic        mem_rdy;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_rdata0;
  logic        mem_rdata_load;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model [int];
  logic [7:0]  last_del = 8'h00;
  logic [7:0]  wbuf [BL];

  mem_responder_6502 #(
    .ADDR_W(ADDR_W), .LATENCY(LAT), .BEAT_WAIT(BW), .BURST_LEN(BL), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_rburst(mem_rburst), .mem_wburst(mem_wburst), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_rdata0(mem_rdata0),
    .mem_rdata_load(mem_rdata_load)
  );

  always #5 clk = ~clk;

  // Byte touched by beat k: offset within the aligned line advances modulo the line size.
  function automatic int exp_addr(input logic [23:0] addr, input int k);
    int base, line;
    base = int'(addr) % (1 << ADDR_W);
    line = (base / BL) * BL;
    return line + ((base % BL) + k) % BL;
  endfunction

  // Called just after a rising edge with the DUT idle (or finishing an ack with mem_en held).
  task automatic run_txn(input string name, input logic [23:0] addr, input bit wr,
                         input bit rb, input bit wb, input bit hold);
    int n, last, k, a;
    bit is_beat;
    logic [7:0] exp_b;
    n    = ((rb && !wr) || (wr && wb && WB_EN)) ? BL : 1;
    last = LAT + 1 + (n - 1) * (BW + 1);
    mem_en = 1'b1; mem_addr = addr; mem_wr = wr; mem_rburst = rb; mem_wburst = wb;
    mem_wdata = wbuf[0];
    @(negedge clk);
    checks++;
    if (mem_rdy !== 1'b1) begin
      errors++; $display("FAIL %s accept: mem_rdy=%b want 1", name, mem_rdy);
    end
    @(posedge clk); #1;
    mem_en = hold; mem_addr = 24'($urandom); mem_wr = 1'($urandom);
    mem_rburst = 1'($urandom); mem_wburst = 1'($urandom);
    k = 0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      is_beat = (c >= LAT + 1) && ((c - LAT - 1) % (BW + 1) == 0);
      checks++;
      if (mem_rdata_load !== is_beat) begin
        errors++; $display("FAIL %s load cyc%0d: got %b want %b", name, c, mem_rdata_load, is_beat);
      end
      checks++;
      if (mem_rdy !== 1'b0) begin
        errors++; $display("FAIL %s busy cyc%0d: mem_rdy=%b want 0", name, c, mem_rdy);
      end
      checks++;
      if (mem_rdata !== last_del) begin
        errors++; $display("FAIL %s held cyc%0d: mem_rdata=%h want %h", name, c, mem_rdata, last_del);
      end
      if (is_beat) begin
        a = exp_addr(addr, k);
        if (wr) begin
          exp_b = wbuf[k];
          model[a] = exp_b;
        end else begin
          exp_b = model.exists(a) ? model[a] : 8'hxx;
        end
        checks++;
        if (mem_rdata0 !== exp_b) begin
          errors++; $display("FAIL %s beat%0d @%h: mem_rdata0=%h want %h", name, k, a, mem_rdata0, exp_b);
        end
        last_del = exp_b;
        k++;
      end
      @(posedge clk); #1;
      if (is_beat && wr && k < BL) mem_wdata = wbuf[k];
    end
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (mem_rdy !== 1'b1 || mem_rdata_load !== 1'b0) begin
        errors++; $display("FAIL %s done: rdy=%b load=%b want 1/0", name, mem_rdy, mem_rdata_load);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_rdy !== 1'b1 || mem_rdata_load !== 1'b0 || mem_rdata !== 8'h00 || mem_rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL reset: rdy=%b load=%b rdata=%h rdata0=%h want 1/0/00/00",
               mem_rdy, mem_rdata_load, mem_rdata, mem_rdata0);
    end
    rst_n = 1'b1;
    last_del = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    wbuf[0] = 8'hA5;
    run_txn("wr_0012", 24'h000012, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("rd_0012", 24'h000012, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] lo;
      lo = 16'($urandom_range(16'h0400, 16'h0FFF));
      wbuf[0] = 8'($urandom);
      run_txn("wr_rand", {8'($urandom), lo}, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn("rd_alias", {8'($urandom), lo}, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_burst;
    for (int i = 0; i < 8; i++) begin
      wbuf[0] = 8'(8'h10 + i);
      run_txn("fill_1238", 24'h001238 + 24'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    run_txn("rb_1238", 24'h001238, 1'b0, 1'b1, 1'b0, 1'b0);
    run_txn("rb_123d", 24'h00123D, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] line;
      line = 16'($urandom_range(16'h0800, 16'h08F8)) & 16'hFFF8;
      for (int j = 0; j < 8; j++) begin
        wbuf[0] = 8'($urandom);
        run_txn("fill_rand", {8'h00, line + 16'(j)}, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      run_txn("rb_rand", {8'($urandom), line + 16'($urandom_range(0, 7))}, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    wbuf[0] = 8'h3C;
    run_txn("b2b_wr_0200", 24'h000200, 1'b1, 1'b0, 1'b0, 1'b1);
    run_txn("b2b_rd_0200", 24'h000200, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      wbuf[0] = 8'($urandom);
      run_txn("b2b_fill", {8'($urandom), 16'h4000 + 16'(i)}, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      bit wr, rb, wb, hold;
      wr   = ($urandom_range(0, 2) == 0);
      rb   = 1'($urandom);
      wb   = 1'($urandom);
      hold = (i != 39) && ($urandom_range(0, 3) != 0);
      for (int j = 0; j < BL; j++) wbuf[j] = 8'($urandom);
      run_txn("b2b_rand", {8'($urandom), 16'h4000 + 16'($urandom_range(0, 63))}, wr, rb, wb, hold);
    end
  endtask

  task automatic test_reset_mid_burst;
    mem_en = 1'b1; mem_addr = 24'h001238; mem_wr = 1'b0; mem_rburst = 1'b1; mem_wburst = 1'b0;
    @(posedge clk); #1;
    mem_en = 1'b0;
    repeat (LAT + 1 + 3 * (BW + 1)) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_rdata_load !== 1'b0 || mem_rdy !== 1'b1 || mem_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: load=%b rdy=%b rdata=%h want 0/1/00", mem_rdata_load, mem_rdy, mem_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_del = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (mem_rdata_load !== 1'b0 || mem_rdy !== 1'b1) begin
        errors++; $display("FAIL rst_quiet cyc%0d: load=%b rdy=%b want 0/1", c, mem_rdata_load, mem_rdy);
      end
    end
    @(posedge clk); #1;
    run_txn("rd_after_rst", 24'h00123B, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write_abort;
    mem_en = 1'b1; mem_addr = 24'h000200; mem_wr = 1'b1; mem_rburst = 1'b0; mem_wdata = 8'h77;
    @(posedge clk); #1;
    mem_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_del = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    run_txn("rd_aborted_wr", 24'h000200, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wburst;
    for (int j = 0; j < 8; j++) begin
      wbuf[0] = 8'($urandom);
      run_txn("fill_0300", 24'h000300 + 24'(j), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int j = 0; j < BL; j++) wbuf[j] = 8'(8'hA0 + j);
    run_txn("wburst_0300", 24'h000300, 1'b1, 1'b0, 1'b1, 1'b0);
    run_txn("rb_0300", 24'h000300, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_write_abort();
    test_wburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
